qpsk_bit_splitter: RTL and testbench

- Consumes the serial data bit stream at the head of the QPSK modulator chain; pairs consecutive bits into one symbol (first bit → I rail, second bit → Q rail).
- Emits both the raw dibit and signed NRZ amplitude levels to the downstream carrier-mixing stage.
- Replaces free-running divide-by-2 phase tracking with a handshake-qualified phase, so bubbles in the input stream never mis-pair bits.
- Sits between the serial bit source and the I/Q mixer.

---
 rtl/qpsk_pkg.sv | 28 ++
 rtl/qpsk_level_map.sv | 21 ++
 rtl/qpsk_bit_splitter.sv | 132 +++++++++++++
 tb/tb_qpsk_bit_splitter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_pkg
// Purpose  : Shared types, constants and the bit-to-NRZ-level mapping used
//            by the QPSK bit splitter and its level mappers.
// Revision : 1.0  initial release
// ============================================================================
package qpsk_pkg;

    localparam int DEF_AMP_W = 8;
    localparam int DEF_AMP   = 127;

    typedef logic signed [DEF_AMP_W-1:0] lvl_t;

    localparam lvl_t LVL_POS = lvl_t'(DEF_AMP);
    localparam lvl_t LVL_NEG = lvl_t'(-DEF_AMP);

    // Phase state: EVEN = waiting for an I bit, ODD = I bit held, waiting for Q
    localparam logic [0:0] ST_EVEN = 1'b0;
    localparam logic [0:0] ST_ODD  = 1'b1;

    // NRZ mapping: bit 0 -> +amp, bit 1 -> -amp
    function automatic int bit_to_level(input logic data_bit, input int amp);
        return data_bit ? -amp : amp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_level_map.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_level_map
// Purpose  : Combinational bit -> signed NRZ amplitude mapper.
// Revision : 1.0  initial release
// ============================================================================
module qpsk_level_map
    import qpsk_pkg::*;
#(
    parameter int AMP_W = DEF_AMP_W,
    parameter int AMP   = DEF_AMP
) (
    input  logic                    data_bit,
    output logic signed [AMP_W-1:0] level
);

    // Truncation is safe because AMP fits in AMP_W-1 magnitude bits
    assign level = AMP_W'(bit_to_level(data_bit, AMP));

endmodule
`default_nettype wire

// File: rtl/qpsk_bit_splitter.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_bit_splitter
// Purpose  : Pairs consecutive serial bits into QPSK dibits (first -> I,
//            second -> Q) with handshake-qualified phase, optional flush
//            padding of a lone I bit, NRZ level outputs and a symbol counter.
// Revision : 1.0  initial release
// ============================================================================
module qpsk_bit_splitter
    import qpsk_pkg::*;
#(
    parameter int AMP_W = DEF_AMP_W,
    parameter int AMP   = DEF_AMP,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_bit,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_i_bit,
    output logic                    out_q_bit,
    output logic signed [AMP_W-1:0] out_i_lvl,
    output logic signed [AMP_W-1:0] out_q_lvl,
    output logic                    out_pad,
    output logic                    odd_pending,
    output logic [CNT_W-1:0]        sym_cnt
);

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic                    r_held;
    logic                    w_slot_free;
    logic                    w_in_acc;
    logic                    w_load_data;
    logic                    w_flush_go;
    logic                    w_load;
    logic                    w_out_acc;
    logic                    w_q_bit;
    logic signed [AMP_W-1:0] w_i_lvl;
    logic signed [AMP_W-1:0] w_q_lvl;

    // Output register may be rewritten in the same cycle it drains
    assign w_slot_free = !out_valid || out_ready;
    assign w_in_acc    = in_valid && in_ready;
    assign w_out_acc   = out_valid && out_ready;
    assign w_load_data = w_in_acc && (r_state == ST_ODD);
    // Flush only pads a held I bit when no real Q bit is offered
    assign w_flush_go  = flush && !in_valid && (r_state == ST_ODD) && w_slot_free;
    assign w_load      = w_load_data || w_flush_go;
    assign w_q_bit     = w_load_data ? in_bit : 1'b0;

    qpsk_level_map #(.AMP_W(AMP_W), .AMP(AMP)) u_map_i (
        .data_bit (r_held),
        .level    (w_i_lvl)
    );

    qpsk_level_map #(.AMP_W(AMP_W), .AMP(AMP)) u_map_q (
        .data_bit (w_q_bit),
        .level    (w_q_lvl)
    );

    // Phase state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_EVEN;
        else        r_state <= w_state_next;
    end

    // Phase advances only on accepted bits or an honoured flush
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EVEN: if (w_in_acc)               w_state_next = ST_ODD;
            ST_ODD:  if (w_in_acc || w_flush_go) w_state_next = ST_EVEN;
            default:                             w_state_next = ST_EVEN;
        endcase
    end

    // Phase-dependent outputs; the Q bit needs a free output slot
    always_comb begin
        in_ready    = 1'b1;
        odd_pending = 1'b0;
        case (r_state)
            ST_ODD: begin
                in_ready    = w_slot_free;
                odd_pending = 1'b1;
            end
            default: begin
                in_ready    = 1'b1;
                odd_pending = 1'b0;
            end
        endcase
    end

    // Capture the I bit of the pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                r_held <= 1'b0;
        else if (w_in_acc && (r_state == ST_EVEN)) r_held <= in_bit;
    end

    // Symbol output register: load wins over drain so there is no bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_i_bit <= 1'b0;
            out_q_bit <= 1'b0;
            out_i_lvl <= '0;
            out_q_lvl <= '0;
            out_pad   <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_i_bit <= r_held;
            out_q_bit <= w_q_bit;
            out_i_lvl <= w_i_lvl;
            out_q_lvl <= w_q_lvl;
            out_pad   <= w_flush_go;
        end else if (w_out_acc) begin
            out_valid <= 1'b0;
        end
    end

    // Count symbols taken by downstream, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         sym_cnt <= '0;
        else if (w_out_acc) sym_cnt <= sym_cnt + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_bit_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpsk_bit_splitter
// Purpose  : Self-checking bench for qpsk_bit_splitter (scoreboard of
//            expected symbols, table-driven pairs, hand-written corner cases).
// Revision : 1.0  initial release
// ============================================================================
module tb_qpsk_bit_splitter;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              out_i_bit;
    logic              out_q_bit;
    logic signed [7:0] out_i_lvl;
    logic signed [7:0] out_q_lvl;
    logic              out_pad;
    logic              odd_pending;
    logic [3:0]        sym_cnt;

    qpsk_bit_splitter #(.AMP_W(8), .AMP(127), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_i_bit   (out_i_bit),
        .out_q_bit   (out_q_bit),
        .out_i_lvl   (out_i_lvl),
        .out_q_lvl   (out_q_lvl),
        .out_pad     (out_pad),
        .odd_pending (odd_pending),
        .sym_cnt     (sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              i;
        logic              q;
        logic signed [7:0] li;
        logic signed [7:0] lq;
        logic              pad;
    } sym_t;

    typedef struct {
        logic              b0;
        logic              b1;
        logic              ei;
        logic              eq;
        logic signed [7:0] eli;
        logic signed [7:0] elq;
    } vec_t;

    sym_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    logic m_phase = 1'b0;

    function automatic logic signed [7:0] nrz(input logic b);
        return b ? -8'sd127 : 8'sd127;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic i, input logic q, input logic pad);
        sym_t s;
        s.i = i; s.q = q; s.li = nrz(i); s.lq = nrz(q); s.pad = pad;
        sb.push_back(s);
    endtask

    // Monitor: every accepted symbol must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            exp_cnt = 0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_symbol: got i=%0b q=%0b pad=%0b, none expected",
                         out_i_bit, out_q_bit, out_pad);
            end else begin
                sym_t e;
                e = sb.pop_front();
                check("sym_i_bit", out_i_bit, e.i);
                check("sym_q_bit", out_q_bit, e.q);
                check("sym_i_lvl", out_i_lvl, e.li);
                check("sym_q_lvl", out_q_lvl, e.lq);
                check("sym_pad",   out_pad,   e.pad);
            end
            check("sym_cnt_at_accept", sym_cnt, exp_cnt % 16);
            exp_cnt++;
        end
    end

    // Offer one bit, wait (bounded) for acceptance, track the pairing phase
    task automatic send_bit(input logic b);
        int waited = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (m_phase == 1'b0) begin
            m_phase = 1'b1;
        end else begin
            m_phase = 1'b0;
            check("out_valid_after_2nd_bit", out_valid, 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb.delete();
        m_phase = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        logic [7:0] hold_i;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  8'sd127,  8'sd127};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1,  8'sd127, -8'sd127};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, -8'sd127,  8'sd127};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, -8'sd127, -8'sd127};

        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_i_bit",   out_i_bit,   0);
        check("rst_out_q_bit",   out_q_bit,   0);
        check("rst_out_i_lvl",   out_i_lvl,   0);
        check("rst_out_q_lvl",   out_q_lvl,   0);
        check("rst_out_pad",     out_pad,     0);
        check("rst_odd_pending", odd_pending, 0);
        check("rst_sym_cnt",     sym_cnt,     0);
        check("rst_in_ready",    in_ready,    1);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Streaming 1,0,0,1
        sb.push_back('{1'b1, 1'b0, -8'sd127,  8'sd127, 1'b0});
        sb.push_back('{1'b0, 1'b1,  8'sd127, -8'sd127, 1'b0});
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        idle(2);
        check("stream_sym_cnt", sym_cnt, 2);

        // Table-driven pairs
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{tbl[k].ei, tbl[k].eq, tbl[k].eli, tbl[k].elq, 1'b0});
            send_bit(tbl[k].b0);
            send_bit(tbl[k].b1);
        end
        idle(2);

        // Backpressure: symbol frozen, phase-0 bit still accepted
        out_ready = 1'b0;
        push(1'b1, 1'b1, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        hold_i = out_i_lvl;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_i_bit",     out_i_bit, 1);
            check("bp_q_bit",     out_q_bit, 1);
            check("bp_i_lvl",     out_i_lvl, -127);
            check("bp_q_lvl",     out_q_lvl, -127);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_bit = 1'b0;
        @(negedge clk);
        check("bp_in_ready_phase0", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_phase = 1'b1;
        @(negedge clk);
        check("bp_in_ready_phase1", in_ready, 0);
        check("bp_odd_pending", odd_pending, 1);
        check("bp_i_lvl_stable", out_i_lvl, $signed(hold_i));
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        check("nobubble_i_bit", out_i_bit, 0);
        check("nobubble_q_bit", out_q_bit, 1);
        idle(2);

        // Flush of a lone I bit
        send_bit(1'b1);
        check("flush_odd_pending_before", odd_pending, 1);
        push(1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_phase = 1'b0;
        check("flush_odd_pending_after", odd_pending, 0);
        check("flush_out_valid", out_valid, 1);
        check("flush_out_pad",   out_pad,   1);
        idle(2);

        // Flush ignored in phase 0
        flush = 1'b1;
        idle(3);
        flush = 1'b0;
        check("flush_ph0_out_valid",   out_valid,   0);
        check("flush_ph0_odd_pending", odd_pending, 0);

        // Flush ignored while a real Q bit is offered
        send_bit(1'b0);
        flush = 1'b1;
        push(1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        flush = 1'b0;
        check("flush_inv_out_pad", out_pad, 0);
        check("flush_inv_odd_pending", odd_pending, 0);
        idle(2);

        // Asynchronous reset with a held I bit and an unconsumed symbol
        out_ready = 1'b0;
        push(1'b1, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("pre_arst_odd_pending", odd_pending, 1);
        check("pre_arst_out_valid",   out_valid,   1);
        #3 reset = 1'b0;
        #1;
        check("arst_out_valid",   out_valid,   0);
        check("arst_out_i_bit",   out_i_bit,   0);
        check("arst_out_q_bit",   out_q_bit,   0);
        check("arst_out_i_lvl",   out_i_lvl,   0);
        check("arst_out_q_lvl",   out_q_lvl,   0);
        check("arst_out_pad",     out_pad,     0);
        check("arst_odd_pending", odd_pending, 0);
        check("arst_sym_cnt",     sym_cnt,     0);
        sb.delete();
        m_phase = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        send_bit(1'b0); send_bit(1'b0);
        check("post_arst_i_lvl", out_i_lvl, 127);
        check("post_arst_q_lvl", out_q_lvl, 127);
        idle(2);

        // Counter wrap with a 4-bit counter
        do_reset();
        for (int k = 0; k < 15; k++) begin
            logic b0, b1;
            b0 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            push(b0, b1, 1'b0);
            send_bit(b0);
            send_bit(b1);
        end
        idle(3);
        check("wrap_sym_cnt_15", sym_cnt, 15);
        push(1'b1, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0);
        idle(3);
        check("wrap_sym_cnt_0", sym_cnt, 0);

        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
